cat_recognizer_apb_master: RTL and testbench

APB initiator that drives the cat recognizer's slave port from a simple command/stream interface. It converts a command (address, beat count, direction) into a burst of single APB transfers with auto-incrementing address: it loads pixel and weight memories and reads back status and result registers. It sits between a host-side loader (DMA, CPU shim or system bench driver) and the `cat_recognizer_interface` APB signals, replacing the stimulus-driven master in system configurations.

---
 rtl/cat_recognizer_pkg.sv | 20 ++
 rtl/cat_recognizer_apb_master_if.sv | 33 +++
 rtl/cat_recognizer_apb_master.sv | 163 ++++++++++++++++
 tb/tb_cat_recognizer_apb_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cat_recognizer_pkg.sv
// Shared definitions for the cat recognizer APB master.
// Holds the APB transfer state type and the default bus widths that the
// interface, the master and the bench all derive their parameters from.
package cat_recognizer_pkg;

  // Default APB data width (PWDATA/PRDATA and the write/read streams).
  localparam int AMBA_WORD_DEFAULT       = 24;
  // Default APB address width; the beat count uses the same width.
  localparam int AMBA_ADDR_DEPTH_DEFAULT = 13;

  // Transfer sequencing: a write beat waits for stream data in WAIT_WR,
  // every beat then spends exactly one cycle in SETUP and one in ACCESS.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WR = 2'd1,
    SETUP   = 2'd2,
    ACCESS  = 2'd3
  } apb_state_t;

endpackage

// File: rtl/cat_recognizer_apb_master_if.sv
// APB2 bus (no PREADY) between the cat recognizer APB master and the
// cat recognizer slave port.
//   PADDR   : transfer address          (master -> slave)
//   PSEL    : slave select              (master -> slave)
//   PENABLE : access phase marker       (master -> slave)
//   PWRITE  : 1 = write, 0 = read       (master -> slave)
//   PWDATA  : write data                (master -> slave)
//   PRDATA  : read data                 (slave  -> master)
interface cat_recognizer_apb_master_if
  import cat_recognizer_pkg::*;
#(
  parameter int Amba_Word       = AMBA_WORD_DEFAULT,
  parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEFAULT
) ();

  logic [Amba_Addr_Depth-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA
  );

endinterface

// File: rtl/cat_recognizer_apb_master.sv
// APB initiator for the cat recognizer slave port.
// Turns a command (first address, beat count minus one, direction) into a
// burst of single APB2 transfers with an auto-incrementing, wrapping address.
// Write beats take their data from a valid/ready stream; read beats return
// data as one-cycle pulses with no backpressure.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   cmd_*      : command handshake (accepted only while idle)
//   wr_*       : write data stream, wr_ready is the consume strobe
//   rd_valid   : one-cycle pulse with rd_data for every read beat
//   busy       : a burst is in progress
//   apb        : APB master side
module cat_recognizer_apb_master
  import cat_recognizer_pkg::*;
#(
  parameter int Amba_Word       = AMBA_WORD_DEFAULT,
  parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [Amba_Addr_Depth-1:0] cmd_addr,
  input  logic [Amba_Addr_Depth-1:0] cmd_len,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [Amba_Word-1:0]       wr_data,
  output logic                       rd_valid,
  output logic [Amba_Word-1:0]       rd_data,
  output logic                       busy,
  cat_recognizer_apb_master_if.master apb
);

  localparam logic [Amba_Addr_Depth-1:0] ONE = Amba_Addr_Depth'(1);

  apb_state_t                 state_q,   state_d;
  logic [Amba_Addr_Depth-1:0] addr_q,    addr_d;    // address of the next beat to issue
  logic [Amba_Addr_Depth-1:0] len_q,     len_d;     // beats remaining after the current one
  logic                       write_q,   write_d;
  logic [Amba_Addr_Depth-1:0] paddr_q,   paddr_d;
  logic                       psel_q,    psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q,  pwrite_d;
  logic [Amba_Word-1:0]       pwdata_q,  pwdata_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [Amba_Word-1:0]       rd_data_q,  rd_data_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    write_d    = write_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          write_d = cmd_write;
          state_d = cmd_write ? WAIT_WR : SETUP;
        end
      end

      WAIT_WR: begin
        if (wr_valid) begin
          wr_ready = 1'b1;
          pwdata_d = wr_data;
          state_d  = SETUP;
        end
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (!write_q) begin
          rd_data_d  = apb.PRDATA;
          rd_valid_d = 1'b1;
        end
        if (len_q == '0) begin
          state_d = IDLE;
        end else begin
          len_d = len_q - ONE;
          if (!write_q) begin
            state_d = SETUP;
          end else if (wr_valid) begin
            // Data already waiting: skip WAIT_WR to sustain 2 cycles per beat.
            wr_ready = 1'b1;
            pwdata_d = wr_data;
            state_d  = SETUP;
          end else begin
            state_d = WAIT_WR;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Bus controls are registered from the next state so they line up with
    // the phase the FSM is entering. Address and direction are only loaded
    // on entry to SETUP (SETUP never follows SETUP), keeping them stable
    // across the whole transfer; the beat address then advances, wrapping
    // naturally at the address width.
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    if (state_d == SETUP) begin
      paddr_d  = addr_d;
      pwrite_d = write_d;
      addr_d   = addr_d + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      write_q    <= 1'b0;
      paddr_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      write_q    <= write_d;
      paddr_q    <= paddr_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

  assign apb.PADDR   = paddr_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_cat_recognizer_apb_master.sv
// Bench for cat_recognizer_apb_master: directed bursts, an expected-beat
// queue built from each command, and a per-cycle monitor on the APB bus and
// read stream. Literal expectations pin addresses, data and burst lengths.
module tb_cat_recognizer_apb_master;
  import cat_recognizer_pkg::*;

  localparam int W = AMBA_WORD_DEFAULT;
  localparam int A = AMBA_ADDR_DEPTH_DEFAULT;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_write = 1'b0;
  logic [A-1:0] cmd_addr = '0;
  logic [A-1:0] cmd_len = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_data = '0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         busy;

  cat_recognizer_apb_master_if #(.Amba_Word(W), .Amba_Addr_Depth(A)) apb ();

  cat_recognizer_apb_master #(.Amba_Word(W), .Amba_Addr_Depth(A)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .apb(apb)
  );

  always #5 clk = ~clk;

  // Slave read data: 1,2,3 at 0x200..0x202, an address-tagged pattern elsewhere.
  function automatic logic [W-1:0] slave_data(input logic [A-1:0] a);
    if (a >= 13'h200 && a <= 13'h202) return W'(a - 13'h1FF);
    return {11'h5A5, a};
  endfunction

  assign apb.PRDATA = slave_data(apb.PADDR);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [A-1:0] addr;
    logic         write;
    logic [W-1:0] data;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        cur;
  logic [A-1:0] addr_seen[$];
  logic [W-1:0] rd_seen[$];
  int           wr_ready_cnt = 0;
  int           gap_cnt = 0;
  int           psel_cnt = 0;
  logic         prev_setup = 1'b0;
  logic         exp_rd_pending = 1'b0;
  logic [W-1:0] exp_rd_data = '0;

  // Monitor: every falling edge, check the bus against the expected beats.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_psel",    apb.PSEL, 0);
      check("rst_penable", apb.PENABLE, 0);
      check("rst_pwrite",  apb.PWRITE, 0);
      check("rst_paddr",   apb.PADDR, 0);
      check("rst_pwdata",  apb.PWDATA, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_busy",    busy, 0);
      exp_q.delete();
      exp_rd_pending = 1'b0;
      prev_setup     = 1'b0;
    end else begin
      check("cmd_ready_vs_busy", cmd_ready, !busy);
      check("rd_valid", rd_valid, exp_rd_pending);
      if (rd_valid && exp_rd_pending) begin
        check("rd_data", rd_data, exp_rd_data);
        rd_seen.push_back(rd_data);
      end
      exp_rd_pending = 1'b0;
      check("wr_ready_in_setup", wr_ready && apb.PSEL && !apb.PENABLE, 0);
      if (wr_ready) wr_ready_cnt++;

      if (apb.PSEL && !apb.PENABLE) begin
        check("setup_after_setup", prev_setup, 0);
        psel_cnt++;
        addr_seen.push_back(apb.PADDR);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_setup: PADDR=%0h with no beat expected at %0t", apb.PADDR, $time);
        end else begin
          cur = exp_q.pop_front();
          check("setup_paddr",  apb.PADDR, cur.addr);
          check("setup_pwrite", apb.PWRITE, cur.write);
          if (cur.write) check("setup_pwdata", apb.PWDATA, cur.data);
        end
      end else if (apb.PSEL && apb.PENABLE) begin
        check("access_after_setup", prev_setup, 1);
        check("access_paddr",  apb.PADDR, cur.addr);
        check("access_pwrite", apb.PWRITE, cur.write);
        if (cur.write) check("access_pwdata", apb.PWDATA, cur.data);
        if (!cur.write) begin
          exp_rd_pending = 1'b1;
          exp_rd_data    = cur.data;
        end
      end else begin
        check("penable_without_psel", apb.PENABLE, 0);
        if (busy) gap_cnt++;
      end
      prev_setup = apb.PSEL && !apb.PENABLE;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input logic w, input logic [A-1:0] a, input int len,
                              input logic [W-1:0] data[$]);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.addr  = a + A'(i);
      b.write = w;
      b.data  = w ? data[i] : slave_data(b.addr);
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_cmd(input logic w, input logic [A-1:0] a, input logic [A-1:0] l);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("cmd_ready_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] d, input int gap);
    wr_valid = 1'b0;
    repeat (gap) align();
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    check("wr_ready_handshake", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [A-1:0] a, input int len,
                             input logic [W-1:0] data[$], input int gaps[$], output int n);
    int cycles;
    align();
    expect_burst(1'b1, a, len, data);
    wr_ready_cnt = 0;
    gap_cnt      = 0;
    addr_seen.delete();
    fork
      for (int i = 0; i <= len; i++) feed(data[i], gaps[i]);
      begin
        issue_cmd(1'b1, a, A'(len));
        wait_idle(cycles);
      end
    join
    n = cycles;
  endtask

  task automatic read_burst(input logic [A-1:0] a, input int len, output int n);
    logic [W-1:0] none[$];
    align();
    expect_burst(1'b0, a, len, none);
    rd_seen.delete();
    addr_seen.delete();
    issue_cmd(1'b0, a, A'(len));
    wait_idle(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] dq[$];
    int           gq[$];
    int           n;

    // Reset state, then release.
    repeat (3) @(negedge clk);
    align();
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);

    // Single write beat.
    dq.delete(); gq.delete();
    dq.push_back(24'hABCDEF); gq.push_back(0);
    write_burst(13'h0010, 0, dq, gq, n);
    check("single_write_cycles", n, 4);
    check("single_write_paddr", addr_seen[0], 13'h0010);
    check("single_write_wr_ready", wr_ready_cnt, 1);

    // Four-beat write, data always available.
    dq.delete(); gq.delete();
    for (int i = 0; i < 4; i++) begin
      dq.push_back(24'h100000 + W'(i));
      gq.push_back(0);
    end
    write_burst(13'h0100, 3, dq, gq, n);
    check("burst4_cycles", n, 10);
    check("burst4_wr_ready", wr_ready_cnt, 4);
    check("burst4_psel_low", gap_cnt, 1);
    check("burst4_addr0", addr_seen[0], 13'h0100);
    check("burst4_addr1", addr_seen[1], 13'h0101);
    check("burst4_addr2", addr_seen[2], 13'h0102);
    check("burst4_addr3", addr_seen[3], 13'h0103);

    // Two-beat write with a 3-cycle data gap before beat 2.
    dq.delete(); gq.delete();
    dq.push_back(24'h111111); gq.push_back(0);
    dq.push_back(24'h222222); gq.push_back(3);
    write_burst(13'h0100, 1, dq, gq, n);
    check("gap_cycles", n, 8);
    check("gap_psel_low", gap_cnt, 3);
    check("gap_addr0", addr_seen[0], 13'h0100);
    check("gap_addr1", addr_seen[1], 13'h0101);

    // Three-beat read.
    read_burst(13'h0200, 2, n);
    check("read3_cycles", n, 7);
    check("read3_count", rd_seen.size(), 3);
    if (rd_seen.size() == 3) begin
      check("read3_data0", rd_seen[0], 24'h000001);
      check("read3_data1", rd_seen[1], 24'h000002);
      check("read3_data2", rd_seen[2], 24'h000003);
    end

    // Address wrap at the top of the space.
    read_burst(13'h1FFF, 1, n);
    check("wrap_cycles", n, 5);
    check("wrap_addr0", addr_seen[0], 13'h1FFF);
    check("wrap_addr1", addr_seen[1], 13'h0000);
    check("wrap_count", rd_seen.size(), 2);
    if (rd_seen.size() == 2) check("wrap_data1", rd_seen[1], 24'hB4A000);

    // Reset during the ACCESS phase of beat 2 of a 4-beat read.
    align();
    begin
      logic [W-1:0] none[$];
      expect_burst(1'b0, 13'h0300, 3, none);
    end
    issue_cmd(1'b0, 13'h0300, 13'd3);
    repeat (4) @(negedge clk);
    check("mid_access_psel", apb.PSEL, 1);
    check("mid_access_penable", apb.PENABLE, 1);
    check("mid_access_paddr", apb.PADDR, 13'h0301);
    #1 rst = 1'b0;
    #1;
    check("async_rst_psel", apb.PSEL, 0);
    check("async_rst_penable", apb.PENABLE, 0);
    check("async_rst_paddr", apb.PADDR, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    align();
    rst = 1'b1;
    psel_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    check("after_rst_no_psel", psel_cnt, 0);
    check("after_rst_busy", busy, 0);
    check("after_rst_cmd_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
